// File: rtl/div16by8_pkg.sv
// Shared types and constants for the 16/8 sequential restoring divider.
package div16by8_pkg;

  localparam int DW    = 8;       // divisor, quotient and remainder width
  localparam int DDW   = 2 * DW;  // dividend width
  localparam int CNT_W = 3;       // step counter width, log2(DW)

  // Quotient/remainder code driven on divide-by-zero or overflow
  localparam logic [DW-1:0] ERR_Q = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div16by8_seq_div_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into
// the partial remainder and subtracts the divisor if it fits.
module div_step #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] pr,
  input  logic          inbit,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] pr_next,
  output logic          qbit
);

  logic [DW:0] t;

  // Trial subtraction on the widened partial remainder
  always_comb begin
    // NOTE: every output gets a value on every path through always_comb, so no latch can be inferred.
    t       = {pr, inbit};
    qbit    = (t >= {1'b0, divisor});
    pr_next = qbit ? DW'(t - {1'b0, divisor}) : t[DW-1:0];
  end

endmodule

// File: rtl/div16by8_seq.sv
// Sequential unsigned divider: 2*DW-bit dividend by DW-bit divisor, one
// quotient bit per clock, valid/ready handshakes on input and output.
// Optional result self-check enabled by defining DIV_SELFCHECK_EN; without
// it chk_err is held at 0 and no checking multiplier exists.
module div16by8_seq #(
  parameter int                  DW    = div16by8_pkg::DW,
  parameter logic [DW-1:0]       ERR_Q = div16by8_pkg::ERR_Q
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   quotient,
  output logic [DW-1:0]   remainder,
  output logic            div_by_zero,
  output logic            overflow,
  output logic            chk_err
);

  import div16by8_pkg::*;

  localparam int              SW   = $clog2(DW);
  localparam logic [SW-1:0]   LAST = SW'(DW - 1);

  state_t        state;
  logic [DW-1:0] pr;      // partial remainder
  logic [DW-1:0] sq;      // dividend low bits shifting out, quotient bits shifting in
  logic [DW-1:0] dvs;     // latched divisor
  logic [SW-1:0] cnt;

  logic [DW-1:0] pr_next;
  logic          qbit;
  logic [DW-1:0] q_fin;
  logic          chk_bad;

  div_step #(.DW(DW)) u_step (
    .pr      (pr),
    .inbit   (sq[DW-1]),
    .divisor (dvs),
    .pr_next (pr_next),
    .qbit    (qbit)
  );

  // Quotient as it will stand after the current step
  assign q_fin = {sq[DW-2:0], qbit};

`ifdef DIV_SELFCHECK_EN
  logic [2*DW-1:0] dvd;
  logic [2*DW-1:0] recon;

  assign recon   = {{DW{1'b0}}, q_fin} * {{DW{1'b0}}, dvs} + {{DW{1'b0}}, pr_next};
  assign chk_bad = (recon != dvd) || (pr_next >= dvs);

  // Keep the full dividend for reconstruction at the end of the operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dvd <= '0;
    else if (state == IDLE && in_valid)
      dvd <= dividend;
  end
`else
  assign chk_bad = 1'b0;
`endif

  // Control FSM and datapath registers, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: asynchronous reset clears every register, so an abort mid-operation leaves no stale state.
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      chk_err     <= 1'b0;
      pr          <= '0;
      sq          <= '0;
      dvs         <= '0;
      cnt         <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register see pre-edge values, independent of statement order.
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dvs <= divisor;
            pr  <= dividend[2*DW-1:DW];
            sq  <= dividend[DW-1:0];
            cnt <= '0;
            if (divisor == '0) begin
              state       <= DONE;
              in_ready    <= 1'b0;
              out_valid   <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= ERR_Q;
              remainder   <= ERR_Q;
            end else if (dividend[2*DW-1:DW] >= divisor) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              overflow  <= 1'b1;
              quotient  <= ERR_Q;
              remainder <= ERR_Q;
            end else begin
              state    <= CALC;
              in_ready <= 1'b0;
            end
          end
        end
        CALC: begin
          pr  <= pr_next;
          sq  <= q_fin;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_fin;
            remainder <= pr_next;
            chk_err   <= chk_bad;
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            chk_err     <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
